// File: rtl/traffic_light_multi.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_multi
// Brief    : N-approach round-robin traffic-light controller with actuated
//            skipping, per-phase durations and emergency all-red hold.
// Revision : 1.0
// ============================================================================
module traffic_light_multi #(
    parameter int NUM_DIR     = 4,
    parameter int CNT_W       = 8,
    parameter int GREEN_TIME  = 63,
    parameter int YELLOW_TIME = 7,
    parameter int ALLRED_TIME = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DIR-1:0]         req,
    input  logic                       actuated,
    input  logic                       hold_red,
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [1:0]                 phase,
    output logic [$clog2(NUM_DIR)-1:0] dir,
    output logic [CNT_W-1:0]           time_left,
    output logic                       prop
);
    localparam int c_DIR_W = $clog2(NUM_DIR);

    localparam logic [1:0] c_ST_ALL_RED = 2'd0;
    localparam logic [1:0] c_ST_GREEN   = 2'd1;
    localparam logic [1:0] c_ST_YELLOW  = 2'd2;

    localparam logic [CNT_W-1:0] c_GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LOAD = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    localparam int c_MAX_GY   = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
    localparam int c_MAX_TIME = (c_MAX_GY > ALLRED_TIME) ? c_MAX_GY : ALLRED_TIME;
    localparam logic [CNT_W-1:0] c_MAX_LOAD = CNT_W'(c_MAX_TIME - 1);

    localparam logic [NUM_DIR-1:0] c_ONE_DIR = NUM_DIR'(1);
    localparam logic [c_DIR_W-1:0] c_LAST_DIR = c_DIR_W'(NUM_DIR - 1);

    logic [1:0]         r_phase;
    logic [c_DIR_W-1:0] r_dir;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_DIR-1:0] r_pending;

    logic [1:0]         w_phase_nxt;
    logic [c_DIR_W-1:0] w_dir_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_DIR-1:0] w_clear;
    logic               w_cnt_zero;
    logic [c_DIR_W-1:0] w_rr_dir;
    logic [c_DIR_W-1:0] w_act_dir;
    logic               w_act_found;
    logic [c_DIR_W-1:0] w_idx;
    logic [c_DIR_W-1:0] w_sel_dir;
    logic [NUM_DIR-1:0] w_dir_onehot;
    logic [NUM_DIR-1:0] w_lamps;

    // Actuated search runs from the far end so the nearest pending approach
    // after the current one wins; the current approach itself is tried last.
    always_comb begin
        w_rr_dir    = (r_dir == c_LAST_DIR) ? '0 : r_dir + c_DIR_W'(1);
        w_act_found = 1'b0;
        w_act_dir   = r_dir;
        w_idx       = '0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            w_idx = c_DIR_W'((int'(r_dir) + k) % NUM_DIR);
            if (r_pending[w_idx]) begin
                w_act_found = 1'b1;
                w_act_dir   = w_idx;
            end
        end
        w_sel_dir = actuated ? w_act_dir : w_rr_dir;
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_clear     = '0;
        w_cnt_zero  = (r_cnt == '0);
        case (r_phase)
            c_ST_GREEN: begin
                if (hold_red || w_cnt_zero) begin
                    w_phase_nxt = c_ST_YELLOW;
                    w_cnt_nxt   = c_YELLOW_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_YELLOW: begin
                if (w_cnt_zero) begin
                    w_phase_nxt = c_ST_ALL_RED;
                    w_cnt_nxt   = c_ALLRED_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                // Hold pins the clearance counter so a full all-red interval
                // follows every release.
                if (hold_red) begin
                    w_cnt_nxt = c_ALLRED_LOAD;
                end else if (w_cnt_zero) begin
                    if (actuated && !w_act_found) begin
                        w_cnt_nxt = c_ALLRED_LOAD;
                    end else begin
                        w_phase_nxt = c_ST_GREEN;
                        w_dir_nxt   = w_sel_dir;
                        w_cnt_nxt   = c_GREEN_LOAD;
                        w_clear     = c_ONE_DIR << w_sel_dir;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase   <= c_ST_ALL_RED;
            r_dir     <= c_LAST_DIR;
            r_cnt     <= c_ALLRED_LOAD;
            r_pending <= '0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_dir     <= w_dir_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= (r_pending | req) & ~w_clear;
        end
    end

    assign w_dir_onehot = c_ONE_DIR << r_dir;
    assign green        = (r_phase == c_ST_GREEN)  ? w_dir_onehot : '0;
    assign yellow       = (r_phase == c_ST_YELLOW) ? w_dir_onehot : '0;
    assign phase        = r_phase;
    assign dir          = r_dir;
    assign time_left    = r_cnt;

    assign w_lamps = green | yellow;
    assign prop    = ((w_lamps & (w_lamps - c_ONE_DIR)) == '0) && (r_cnt <= c_MAX_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_multi
// Brief    : Directed + random bench for traffic_light_multi against a
//            phase-elapsed behavioural model; also drives a 1-cycle corner.
// Revision : 1.0
// ============================================================================
module tb_traffic_light_multi;
    localparam int N  = 4;
    localparam int GT = 63;
    localparam int YT = 7;
    localparam int AT = 3;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       actuated;
    logic       hold_red;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [1:0] phase;
    logic [1:0] dir;
    logic [7:0] time_left;
    logic       prop;

    logic [3:0] c_req;
    logic       c_act;
    logic       c_hold;
    logic [3:0] c_green;
    logic [3:0] c_yellow;
    logic [1:0] c_phase;
    logic [1:0] c_dir;
    logic [7:0] c_time_left;
    logic       c_prop;

    traffic_light_multi dut (
        .clk(clk), .reset(reset), .req(req), .actuated(actuated), .hold_red(hold_red),
        .green(green), .yellow(yellow), .phase(phase), .dir(dir),
        .time_left(time_left), .prop(prop)
    );

    traffic_light_multi #(
        .NUM_DIR(4), .CNT_W(8), .GREEN_TIME(1), .YELLOW_TIME(1), .ALLRED_TIME(1)
    ) dut_corner (
        .clk(clk), .reset(reset), .req(c_req), .actuated(c_act), .hold_red(c_hold),
        .green(c_green), .yellow(c_yellow), .phase(c_phase), .dir(c_dir),
        .time_left(c_time_left), .prop(c_prop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Model: phase id (0 red, 1 green, 2 yellow), served approach, phase
    // length and cycles already spent in it.
    int       m_phase;
    int       m_dir;
    int       m_dur;
    int       m_elapsed;
    bit [3:0] m_pend;
    bit       m_valid = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit [3:0] old;
        bit       last;
        bit       found;
        int       nxt;
        if (reset) begin
            m_phase = 0; m_dir = N - 1; m_dur = AT; m_elapsed = 0; m_pend = '0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        old    = m_pend;
        m_pend = m_pend | req;
        last   = (m_elapsed == m_dur - 1);
        case (m_phase)
            1: if (hold_red || last) begin m_phase = 2; m_dur = YT; m_elapsed = 0; end
               else m_elapsed++;
            2: if (last) begin m_phase = 0; m_dur = AT; m_elapsed = 0; end
               else m_elapsed++;
            default: begin
                if (hold_red) m_elapsed = 0;
                else if (last) begin
                    found = 1'b0;
                    nxt   = m_dir;
                    if (!actuated) begin
                        found = 1'b1;
                        nxt   = (m_dir + 1) % N;
                    end else begin
                        for (int k = 1; k <= N; k++)
                            if (!found && old[(m_dir + k) % N]) begin
                                found = 1'b1;
                                nxt   = (m_dir + k) % N;
                            end
                    end
                    if (found) begin
                        m_phase = 1; m_dir = nxt; m_dur = GT; m_elapsed = 0;
                        m_pend[nxt] = 1'b0;
                    end else begin
                        m_elapsed = 0;
                    end
                end else m_elapsed++;
            end
        endcase
    endtask

    bit c_valid = 1'b0;

    task automatic tick();
        bit [3:0] exp_g;
        bit [3:0] exp_y;
        @(posedge clk);
        model_step();
        if (reset) c_valid = 1'b1;
        #1;
        if (m_valid) begin
            exp_g = (m_phase == 1) ? (4'b0001 << m_dir) : 4'b0000;
            exp_y = (m_phase == 2) ? (4'b0001 << m_dir) : 4'b0000;
            check("phase", phase, m_phase);
            check("dir", dir, m_dir);
            check("time_left", time_left, m_dur - 1 - m_elapsed);
            check("green", green, exp_g);
            check("yellow", yellow, exp_y);
            check("prop", prop, 1);
        end
        if (c_valid) begin
            check("corner_prop", c_prop, 1);
            check("corner_time_left", c_time_left, 0);
        end
        c_req  = 4'($urandom);
        c_act  = 1'($urandom_range(0, 1));
        c_hold = ($urandom_range(0, 7) == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; req = '0; actuated = 1'b0; hold_red = 1'b0;
        c_req = '0; c_act = 1'b0; c_hold = 1'b0;

        // Fixed-time cycle from reset
        tick();
        reset = 1'b0;
        check("lit_rst_phase", phase, 0);
        check("lit_rst_dir", dir, 3);
        check("lit_rst_tl", time_left, 2);
        check("lit_rst_lamps", {green, yellow}, 0);
        ticks(3);
        check("lit_g0", green, 4'b0001);
        check("lit_g0_tl", time_left, 62);
        ticks(62);
        check("lit_g0_end_tl", time_left, 0);
        tick();
        check("lit_y0", yellow, 4'b0001);
        check("lit_y0_tl", time_left, 6);
        ticks(7);
        check("lit_ar0", {phase, dir, time_left}, {2'd0, 2'd0, 8'd2});
        ticks(3);
        check("lit_g1", green, 4'b0010);

        // Actuated single request
        reset = 1'b1; actuated = 1'b1;
        tick();
        reset = 1'b0; req = 4'b0100;
        tick();
        req = '0;
        ticks(2);
        check("lit_act_g2", green, 4'b0100);
        ticks(70);
        check("lit_act_ar", {phase, time_left}, {2'd0, 8'd2});
        ticks(3);
        check("lit_act_loop", {phase, dir, time_left}, {2'd0, 2'd2, 8'd2});
        tick();
        check("lit_act_loop_tl", time_left, 1);

        // Actuated serve order 1, 3, 0
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("lit_serve_g0", green, 4'b0001);
        ticks(9);
        req = 4'b1011;
        tick();
        req = '0;
        ticks(63);
        check("lit_serve_g1", green, 4'b0010);
        ticks(73);
        check("lit_serve_g3", green, 4'b1000);
        ticks(73);
        check("lit_serve_g0b", green, 4'b0001);

        // Emergency hold at green cycle 10
        actuated = 1'b0;
        ticks(10);
        hold_red = 1'b1;
        tick();
        check("lit_hold_y", {yellow, time_left}, {4'b0001, 8'd6});
        ticks(14);
        check("lit_hold_ar", {phase, time_left}, {2'd0, 8'd2});
        hold_red = 1'b0;
        ticks(2);
        check("lit_rel_ar", {phase, time_left}, {2'd0, 8'd0});
        tick();
        check("lit_rel_g1", green, 4'b0010);

        // Reset mid-yellow with pending requests
        actuated = 1'b1;
        req = 4'b0110;
        tick();
        req = '0;
        ticks(65);
        check("lit_mid_y", phase, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("lit_mid_rst", {phase, dir, time_left, green, yellow}, {2'd0, 2'd3, 8'd2, 8'd0});
        ticks(3);
        check("lit_mid_idle", {phase, dir, time_left}, {2'd0, 2'd3, 8'd2});

        // Random traffic against the model
        for (int i = 0; i < 1000; i++) begin
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) actuated = ~actuated;
            if ($urandom_range(0, 39) == 0) hold_red = ~hold_red;
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
- Parametrised N-approach traffic-light controller; next generation of the single-approach red/green/yellow counter block.
- Serves approaches round-robin: GREEN -> YELLOW -> ALL_RED -> next approach.
- Adds configurable per-phase durations, vehicle-request latching with skip of idle approaches (actuated mode), and an emergency all-red hold.
- Sits in the formal-verification example set; exposes a safety property output for the checker.

Parameters:
- NUM_DIR, 4, number of approaches (2..8)
- CNT_W, 8, counter width in bits
- GREEN_TIME, 63, green phase length in cycles (1..2^CNT_W-1)
- YELLOW_TIME, 7, yellow phase length in cycles (1..2^CNT_W-1)
- ALLRED_TIME, 3, all-red clearance length in cycles (1..2^CNT_W-1)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req  input  NUM_DIR  per-approach vehicle request pulses, latched internally
- actuated  input  1  1 = skip approaches with no latched request; 0 = fixed-time round-robin
- hold_red  input  1  emergency: drive all approaches to red and hold while high
- green  output  NUM_DIR  one-hot green lamp, or all zero
- yellow  output  NUM_DIR  one-hot yellow lamp, or all zero
- phase  output  2  0 = ALL_RED, 1 = GREEN, 2 = YELLOW; 3 never driven
- dir  output  $clog2(NUM_DIR)  approach currently served, or last served while in ALL_RED
- time_left  output  CNT_W  remaining cycles in current phase minus one
- prop  output  1  safety: (green|yellow) has at most one bit set, and time_left <= max(GREEN_TIME, YELLOW_TIME, ALLRED_TIME) - 1

Behaviour:
- Reset (sync, highest priority) sets:
  - phase = ALL_RED, dir = NUM_DIR-1, time_left = ALLRED_TIME-1
  - pending = 0, green = 0, yellow = 0
- Reset asserted mid-phase overrides all other inputs that cycle.
- Phase timing:
  - On entry, the counter loads T-1; each cycle it decrements while nonzero.
  - The transition occurs on the clock edge where counter == 0, so every phase lasts exactly T cycles.
  - No wrap-around: the counter never decrements from 0.
- Transitions at counter == 0:
  - GREEN -> YELLOW, same dir, load YELLOW_TIME-1.
  - YELLOW -> ALL_RED, same dir, load ALLRED_TIME-1.
  - ALL_RED -> GREEN on next approach nxt, load GREEN_TIME-1.
- Selecting nxt:
  - actuated = 0: nxt = (dir+1) mod NUM_DIR.
  - actuated = 1: nxt = first index with pending set, searching dir+1, dir+2, ... wrapping, and including dir itself last.
  - actuated = 1 with pending all zero: stay in ALL_RED, reload ALLRED_TIME-1, dir unchanged.
- Request latching: pending[i] |= req[i] every cycle.
  - pending[nxt] clears on the GREEN entry edge.
  - A req[nxt] pulse on that same edge is lost (clear wins); its approach is being served.
- hold_red:
  - In GREEN: force YELLOW next edge regardless of counter, load YELLOW_TIME-1.
  - In YELLOW: timing is unaffected.
  - In ALL_RED: counter is held at ALLRED_TIME-1 and no exit occurs while asserted.
  - After deassertion, the full ALLRED_TIME elapses before the next GREEN.
  - Requests keep latching during the hold.
- Output decode (registered state, combinational decode):
  - green[dir] = (phase == GREEN); yellow[dir] = (phase == YELLOW); all other bits 0.
- prop must be 1 in every reachable state; the bench asserts it every cycle.

Test Plan:
- Reset, actuated=0, defaults, NUM_DIR=4:
  - ALL_RED 3 cycles, then green=0001 for 63 cycles, yellow=0001 for 7, all-red 3, then green=0010.
  - time_left counts 62..0 in green.
- actuated=1, single req[2] pulse during reset-release all-red:
  - Next green is dir=2 (0100); pending[2] clears.
  - With no further requests, the controller loops in ALL_RED with time_left cycling 2,1,0.
- actuated=1, req=1011 latched during a dir=0 green:
  - Serve order after yellow/all-red is 1, then 3, then 0 (round-robin skipping 2).
- hold_red pulsed high at green cycle 10:
  - Yellow begins next edge for 7 cycles, then all-red.
  - Held while high; green resumes exactly 3 cycles after deassertion.
- Reset asserted mid-YELLOW with pending=0110:
  - Next cycle phase=0, dir=3, time_left=2, pending=0, green=yellow=0.
- Corner parameters GREEN_TIME=YELLOW_TIME=ALLRED_TIME=1, CNT_W=8:
  - Each phase lasts one cycle; time_left stays 0; prop remains 1 over 1000 random cycles.
